// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch FIFO between core fetch port and memory.
// Ports: clk_i/rst_i (async active-high) clock/reset; flush_i drops buffered and in-flight data;
// req_i/addr_i/gnt_o/rvalid_o/rdata_o core-side fetch port; mem_req_o/mem_addr_o/mem_gnt_i/
// mem_rvalid_i/mem_rdata_i memory-side port; hit_cnt_o/miss_cnt_o statistics, live only when
// INSTR_PREFETCH_STATS_EN is defined, otherwise tied to zero.
module instr_prefetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 16;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [CW-1:0]         occ_q, occ_d, outst_q, outst_d;
  logic [SW-1:0]         stale_q, stale_d;
  logic                  pend_q, pend_d, pend_stale_q, pend_stale_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
  logic match, hit, miss, kill, pop, push, room, hs, gnt_stale, gnt_live, resp_stale, resp_live;
  logic [ADDR_WIDTH-1:0] new_addr;
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];
  always_comb begin
    match      = head_addr_q[ADDR_WIDTH-1:2] == addr_i[ADDR_WIDTH-1:2];
    hit        = req_i && active_q && match && occ_q != '0;
    // An empty-buffer match while active is a wait: the head word is either in flight or is
    // exactly the next address to be requested, so the stream must not be restarted.
    miss       = req_i && !(active_q && match);
    kill       = miss || flush_i;
    pop        = hit && !flush_i;
    new_addr   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    room       = ({1'b0, occ_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
    // A raised but ungranted request is held unchanged even across a miss or flush.
    mem_req_o  = pend_q || (active_q && room && !kill);
    mem_addr_o = pend_q ? pend_addr_q : fetch_addr_q;
    hs         = mem_req_o && mem_gnt_i;
    gnt_stale  = hs && (pend_stale_q || kill);
    gnt_live   = hs && !gnt_stale;
    resp_stale = mem_rvalid_i && stale_q != '0;
    resp_live  = mem_rvalid_i && !resp_stale && outst_q != '0;
    push       = resp_live && !kill;
    active_d     = flush_i ? 1'b0 : (miss ? 1'b1 : active_q);
    head_addr_d  = kill ? new_addr : (pop ? head_addr_q + ADDR_WIDTH'(4) : head_addr_q);
    fetch_addr_d = kill ? new_addr : (gnt_live ? fetch_addr_q + ADDR_WIDTH'(4) : fetch_addr_q);
    occ_d        = kill ? '0 : occ_q + CW'(push) - CW'(pop);
    outst_d      = kill ? '0 : outst_q + CW'(gnt_live) - CW'(resp_live);
    stale_d      = stale_q - SW'(resp_stale) + SW'(gnt_stale) + (kill ? SW'(outst_q) - SW'(resp_live) : '0);
    pend_d       = mem_req_o && !mem_gnt_i;
    pend_stale_d = pend_d && (pend_stale_q || kill);
    pend_addr_d  = mem_addr_o;
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = kill ? wr_ptr_q : (pop ? rd_ptr_q + 1'b1 : rd_ptr_q);
  end
  assign gnt_o    = pop;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q     <= 1'b0;
      head_addr_q  <= '0;
      fetch_addr_q <= '0;
      pend_addr_q  <= '0;
      occ_q        <= '0;
      outst_q      <= '0;
      stale_q      <= '0;
      pend_q       <= 1'b0;
      pend_stale_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      active_q     <= active_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      occ_q        <= occ_d;
      outst_q      <= outst_d;
      stale_q      <= stale_d;
      pend_q       <= pend_d;
      pend_stale_q <= pend_stale_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rvalid_q     <= pop;
      if (pop) rdata_q <= fifo_q[rd_ptr_q];
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata_i;
  end
`ifdef INSTR_PREFETCH_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pop && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: scoreboard bench for instr_prefetch_buffer with a latency-programmable memory model.
module tb_instr_prefetch_buffer;
  logic        clk = 1'b0;
  logic        rst, flush, req, gnt, rvalid, mem_req, mem_gnt, mem_rvalid;
  logic [31:0] addr, rdata, mem_addr, mem_rdata, hit_cnt, miss_cnt;
  int tests = 0, fails = 0, cyc = 0, lat = 1, occ_max = 0;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  typedef struct {logic [31:0] addr; int due;} mem_t;
  exp_t        exp_q[$];
  exp_t        e_mon;
  mem_t        mq[$];
  logic [31:0] hs_log[$];
  logic        held = 1'b0;
  logic [31:0] held_addr = '0;
  instr_prefetch_buffer dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req), .addr_i(addr),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (mem_req && mem_gnt) begin
    mq.push_back('{mem_addr, cyc + lat});
    hs_log.push_back(mem_addr);
  end
  always @(posedge clk) begin
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end
  always @(negedge clk) if (!rst && rvalid) begin
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_rvalid: got data %h expected no response", rdata);
    end else begin
      e_mon = exp_q.pop_front();
      check("rdata", rdata, e_mon.data);
      check("rvalid_cycle", cyc, e_mon.cyc);
    end
  end
  always @(negedge clk) begin
    if (held) begin
      check("mem_req_hold", 32'(mem_req), 1);
      check("mem_addr_hold", mem_addr, held_addr);
    end
    held      = mem_req && !mem_gnt && !rst;
    held_addr = mem_addr;
    if (!rst && int'(dut.occ_q) + int'(dut.outst_q) > occ_max) occ_max = int'(dut.occ_q) + int'(dut.outst_q);
  end
  task automatic fetch(input logic [31:0] a, output int waits);
    bit done = 0;
    req = 1'b1;
    addr = a;
    waits = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (gnt) begin
        exp_q.push_back('{word(a), cyc + 1});
        done = 1;
      end else waits++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: no gnt for addr %h, required within 60 cycles", a);
      req = 1'b0;
    end
  endtask
  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask
  initial begin
    int w, sum, n0;
    rst = 1'b1; flush = 1'b0; req = 1'b0; addr = '0; mem_gnt = 1'b1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_rdata", rdata, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch(32'h1000, w);
    check("miss_latency", w, 3);
    idle(8);
    check("prefetch_count", hs_log.size(), 5);
    for (int i = 0; i < 4; i++) check("prefetch_addr", hs_log[i], 32'h1000 + 32'(4 * i));
    occ_max = 0;
    sum = 0;
    for (int i = 1; i < 16; i++) begin
      fetch(32'h1000 + 32'(4 * i), w);
      sum += w;
    end
    check("seq_waits", sum, 0);
    idle(8);
    check("occ_cap", 32'(occ_max <= 4), 1);
    lat = 5;
    for (int i = 0; i < 4; i++) fetch(32'h1040 + 32'(4 * i), w);
    check("inflight_at_branch", mq.size(), 3);
    fetch(32'h2000, w);
    fetch(32'h2004, w);
    idle(12);
    lat = 1;
    idle(6);
    flush_pulse();
    idle(3);
    n0 = hs_log.size();
    mem_gnt = 1'b0;
    req = 1'b1;
    addr = 32'h1000;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    addr = 32'h3000;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    mem_gnt = 1'b1;
    fetch(32'h3000, w);
    idle(8);
    check("held_then_granted", hs_log[n0], 32'h1000);
    check("restart_addr", hs_log[n0 + 1], 32'h3000);
    req = 1'b1;
    addr = 32'h3004;
    flush = 1'b1;
    @(negedge clk);
    check("gnt_under_flush", 32'(gnt), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("flush_mem_req", 32'(mem_req), 0);
    check("flush_active", 32'(dut.active_q), 0);
    check("flush_occ", 32'(dut.occ_q), 0);
    @(posedge clk);
    #1;
    idle(4);
    for (int i = 0; i < 8; i++) fetch(32'(4 * i), w);
    for (int i = 0; i < 4; i++) fetch(32'h4000 + 32'(4 * i), w);
    idle(10);
`ifdef INSTR_PREFETCH_STATS_EN
    check("miss_cnt", miss_cnt, 2);
    check("hit_cnt", hit_cnt, 12);
`else
    check("miss_cnt", miss_cnt, 0);
    check("hit_cnt", hit_cnt, 0);
`endif
    check("pending_responses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
